// File: rtl/tug_match_referee.sv
// Referee for the tug-of-war game: detects end-of-field presses, keeps a
// saturating score per player, sequences the round restart and ends the
// match when one player reaches MATCH_POINTS.
module tug_match_referee #(
  parameter int FIELD_W      = 9,
  parameter int SCORE_W      = 4,
  parameter int MATCH_POINTS = 7,
  parameter int HOLDOFF      = 2
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               L,
  input  logic               R,
  input  logic [FIELD_W-1:0] field,
  input  logic               new_match,
  output logic               point_l,
  output logic               point_r,
  output logic               round_restart,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               match_over,
  output logic               winner_l,
  output logic               winner_r,
  output logic [6:0]         HEX1,
  output logic [6:0]         HEX0
);

  localparam int CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [CNT_W-1:0]   HOLD_LOAD = (HOLDOFF > 0) ? CNT_W'(HOLDOFF - 1) : '0;
  localparam logic [SCORE_W-1:0] MP        = SCORE_W'(MATCH_POINTS);
  localparam logic [SCORE_W-1:0] SMAX      = '1;

  typedef enum logic [1:0] {PLAY, POINT, HOLD, OVER} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               left_hit;
  logic               right_hit;
  logic               unused_field;

  // Score increment that sticks at the counter maximum instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == SMAX) ? v : v + 1'b1;
  endfunction

  // Active-low 7-segment pattern (gfedcba); anything above 9 is blank.
  function automatic logic [6:0] seg7(input logic [SCORE_W-1:0] v);
    logic [31:0] w;
    w = 32'(v);
    case (w)
      32'd0:   return 7'b1000000;
      32'd1:   return 7'b1111001;
      32'd2:   return 7'b0100100;
      32'd3:   return 7'b0110000;
      32'd4:   return 7'b0011001;
      32'd5:   return 7'b0010010;
      32'd6:   return 7'b0000010;
      32'd7:   return 7'b1111000;
      32'd8:   return 7'b0000000;
      32'd9:   return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Each edge light is judged on its own bit; simultaneous presses never score.
  assign left_hit  = field[FIELD_W-1] & L & ~R;
  assign right_hit = field[0] & R & ~L;
  // Interior lights carry no scoring meaning.
  assign unused_field = ^field;

  assign HEX1 = seg7(score_l);
  assign HEX0 = seg7(score_r);

  // Referee FSM with registered pulses, restart, scores and winner flags.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state         <= PLAY;
      cnt           <= '0;
      score_l       <= '0;
      score_r       <= '0;
      point_l       <= 1'b0;
      point_r       <= 1'b0;
      round_restart <= 1'b0;
      match_over    <= 1'b0;
      winner_l      <= 1'b0;
      winner_r      <= 1'b0;
    end else begin
      point_l <= 1'b0;
      point_r <= 1'b0;
      case (state)
        PLAY: begin
          if (left_hit) begin
            state         <= POINT;
            score_l       <= sat_inc(score_l);
            point_l       <= 1'b1;
            round_restart <= 1'b1;
          end else if (right_hit) begin
            state         <= POINT;
            score_r       <= sat_inc(score_r);
            point_r       <= 1'b1;
            round_restart <= 1'b1;
          end
        end
        POINT: begin
          if (score_l == MP || score_r == MP) begin
            state      <= OVER;
            match_over <= 1'b1;
            winner_l   <= (score_l == MP);
            winner_r   <= (score_r == MP);
          end else if (HOLDOFF > 0) begin
            state <= HOLD;
            cnt   <= HOLD_LOAD;
          end else begin
            state         <= PLAY;
            round_restart <= 1'b0;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state         <= PLAY;
            round_restart <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        OVER: begin
          if (new_match) begin
            score_l    <= '0;
            score_r    <= '0;
            winner_l   <= 1'b0;
            winner_r   <= 1'b0;
            match_over <= 1'b0;
            if (HOLDOFF > 0) begin
              state <= HOLD;
              cnt   <= HOLD_LOAD;
            end else begin
              state         <= PLAY;
              round_restart <= 1'b0;
            end
          end
        end
        default: state <= PLAY;
      endcase
    end
  end

endmodule
